// File: rtl/punc_controller.sv
// PUNC (LC-3 subset) control unit: six-state sequencer driving datapath strobes.
// Optional LDI/STI support when PUNC_INDIRECT_EN is defined; otherwise they halt.
//
// Ports:
//   clk, rst (sync, active-low), ir[15:0] current instruction, nzp_true branch cond.
//   PC:  pc_ld, pc_clr, pc_inc, pc_sel[1:0]
//   IR:  ir_ld, ir_clr
//   MEM: mem_rd, mem_wr, mem_r_addr_sel[1:0], mem_w_addr_sel[1:0], mem_r_prev_sel
//   RF:  rf_w_data_sel[1:0], rf_w_addr_sel, rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd
//   misc: prev_ld, nzp_ld, nzp_clr, alu_sel[1:0], alu_first_val_sel, halted
// Read strobes (mem_rd, rf_r0_rd, rf_r1_rd) are raised whenever that port's data is consumed.

`ifndef PUNC_DEFINES_V
`define PUNC_DEFINES_V
`define PC_SEL_PC_8_0       2'd0
`define PC_SEL_PC_10_0      2'd1
`define PC_SEL_RF_R1_DATA   2'd2
`define MEM_R_ADDR_PC       2'd0
`define MEM_R_ADDR_PC_8_0   2'd1
`define MEM_R_ADDR_R1_5_0   2'd2
`define MEM_W_ADDR_PC_8_0   2'd0
`define MEM_W_ADDR_R1_5_0   2'd1
`define MEM_W_ADDR_PREV     2'd2
`define RF_W_DATA_ALU       2'd0
`define RF_W_DATA_MEM_R     2'd1
`define RF_W_DATA_PC_8_0    2'd2
`define RF_W_DATA_PC        2'd3
`define RF_W_ADDR_11_9      1'b0
`define RF_W_ADDR_R7        1'b1
`define RF_R0_ADDR_2_0      1'b0
`define RF_R0_ADDR_11_9     1'b1
`define ALU_ADD             2'd0
`define ALU_AND             2'd1
`define ALU_NOT_B           2'd2
`define ALU_A_R0_DATA       1'b0
`define ALU_A_4_0           1'b1
`endif

module punc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        nzp_true,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_sel,
    output logic        ir_ld,
    output logic        ir_clr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_r_addr_sel,
    output logic [1:0]  mem_w_addr_sel,
    output logic        mem_r_prev_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        rf_w_wr,
    output logic        rf_r0_addr_sel,
    output logic        rf_r0_rd,
    output logic        rf_r1_rd,
    output logic        prev_ld,
    output logic        nzp_ld,
    output logic        nzp_clr,
    output logic [1:0]  alu_sel,
    output logic        alu_first_val_sel,
    output logic        halted
);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT
    } state_t;

    state_t     state_q, state_d, cur;
    logic [3:0] op;
    logic       unused_ir;

    assign op        = ir[15:12];
    assign unused_ir = ^{ir[8:6], ir[4:0]};

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        // Holding rst low shows INIT outputs immediately, before the edge lands.
        cur               = rst ? state_q : S_INIT;
        state_d           = cur;
        pc_ld             = 1'b0;
        pc_clr            = 1'b0;
        pc_inc            = 1'b0;
        pc_sel            = 2'd0;
        ir_ld             = 1'b0;
        ir_clr            = 1'b0;
        mem_rd            = 1'b0;
        mem_wr            = 1'b0;
        mem_r_addr_sel    = 2'd0;
        mem_w_addr_sel    = 2'd0;
        mem_r_prev_sel    = 1'b0;
        rf_w_data_sel     = 2'd0;
        rf_w_addr_sel     = 1'b0;
        rf_w_wr           = 1'b0;
        rf_r0_addr_sel    = 1'b0;
        rf_r0_rd          = 1'b0;
        rf_r1_rd          = 1'b0;
        prev_ld           = 1'b0;
        nzp_ld            = 1'b0;
        nzp_clr           = 1'b0;
        alu_sel           = 2'd0;
        alu_first_val_sel = 1'b0;
        halted            = 1'b0;

        unique case (cur)
            S_INIT: begin
                pc_clr  = 1'b1;
                ir_clr  = 1'b1;
                nzp_clr = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_rd         = 1'b1;
                mem_r_addr_sel = `MEM_R_ADDR_PC;
                ir_ld          = 1'b1;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                pc_inc = 1'b1;
                if (op == OP_HALT)
                    state_d = S_HALT;
`ifndef PUNC_INDIRECT_EN
                else if (op == OP_LDI || op == OP_STI)
                    state_d = S_HALT;
`endif
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_AND: begin
                        alu_sel  = (op == OP_ADD) ? `ALU_ADD : `ALU_AND;
                        rf_r1_rd = 1'b1;
                        if (ir[5]) begin
                            alu_first_val_sel = `ALU_A_4_0;
                        end else begin
                            alu_first_val_sel = `ALU_A_R0_DATA;
                            rf_r0_addr_sel    = `RF_R0_ADDR_2_0;
                            rf_r0_rd          = 1'b1;
                        end
                        rf_w_data_sel = `RF_W_DATA_ALU;
                        rf_w_addr_sel = `RF_W_ADDR_11_9;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    OP_NOT: begin
                        alu_sel       = `ALU_NOT_B;
                        rf_r1_rd      = 1'b1;
                        rf_w_data_sel = `RF_W_DATA_ALU;
                        rf_w_addr_sel = `RF_W_ADDR_11_9;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    OP_LD, OP_LDR: begin
                        mem_rd = 1'b1;
                        if (op == OP_LD) begin
                            mem_r_addr_sel = `MEM_R_ADDR_PC_8_0;
                        end else begin
                            mem_r_addr_sel = `MEM_R_ADDR_R1_5_0;
                            rf_r1_rd       = 1'b1;
                        end
                        rf_w_data_sel = `RF_W_DATA_MEM_R;
                        rf_w_addr_sel = `RF_W_ADDR_11_9;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    OP_LEA: begin
                        rf_w_data_sel = `RF_W_DATA_PC_8_0;
                        rf_w_addr_sel = `RF_W_ADDR_11_9;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        if (op == OP_ST) begin
                            mem_w_addr_sel = `MEM_W_ADDR_PC_8_0;
                        end else begin
                            mem_w_addr_sel = `MEM_W_ADDR_R1_5_0;
                            rf_r1_rd       = 1'b1;
                        end
                        rf_r0_addr_sel = `RF_R0_ADDR_11_9;
                        rf_r0_rd       = 1'b1;
                        mem_wr         = 1'b1;
                    end
                    OP_BR: begin
                        // An empty nzp field must never branch.
                        if (nzp_true && (ir[11:9] != 3'b000)) begin
                            pc_ld  = 1'b1;
                            pc_sel = `PC_SEL_PC_8_0;
                        end
                    end
                    OP_JMP: begin
                        pc_sel   = `PC_SEL_RF_R1_DATA;
                        pc_ld    = 1'b1;
                        rf_r1_rd = 1'b1;
                    end
                    OP_JSR: begin
                        // Link and jump share the edge, so JSRR R7 sees the old R7.
                        rf_w_addr_sel = `RF_W_ADDR_R7;
                        rf_w_data_sel = `RF_W_DATA_PC;
                        rf_w_wr       = 1'b1;
                        pc_ld         = 1'b1;
                        if (ir[11]) begin
                            pc_sel = `PC_SEL_PC_10_0;
                        end else begin
                            pc_sel   = `PC_SEL_RF_R1_DATA;
                            rf_r1_rd = 1'b1;
                        end
                    end
`ifdef PUNC_INDIRECT_EN
                    OP_LDI, OP_STI: begin
                        mem_rd         = 1'b1;
                        mem_r_addr_sel = `MEM_R_ADDR_PC_8_0;
                        prev_ld        = 1'b1;
                        state_d        = S_EXEC2;
                    end
`endif
                    default: ;
                endcase
            end
            S_EXEC2: begin
                state_d = S_FETCH;
`ifdef PUNC_INDIRECT_EN
                if (op == OP_LDI) begin
                    mem_rd         = 1'b1;
                    mem_r_prev_sel = 1'b1;
                    rf_w_data_sel  = `RF_W_DATA_MEM_R;
                    rf_w_addr_sel  = `RF_W_ADDR_11_9;
                    rf_w_wr        = 1'b1;
                    nzp_ld         = 1'b1;
                end else if (op == OP_STI) begin
                    mem_w_addr_sel = `MEM_W_ADDR_PREV;
                    rf_r0_addr_sel = `RF_R0_ADDR_11_9;
                    rf_r0_rd       = 1'b1;
                    mem_wr         = 1'b1;
                end
`endif
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_punc_controller.sv
// Self-checking bench for punc_controller: directed LC-3 cases plus random
// instructions, each checked cycle by cycle against a per-instruction step plan.

module tb_punc_controller;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        nzp_true;
    logic        pc_ld, pc_clr, pc_inc;
    logic [1:0]  pc_sel;
    logic        ir_ld, ir_clr, mem_rd, mem_wr;
    logic [1:0]  mem_r_addr_sel, mem_w_addr_sel;
    logic        mem_r_prev_sel;
    logic [1:0]  rf_w_data_sel;
    logic        rf_w_addr_sel, rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd;
    logic        prev_ld, nzp_ld, nzp_clr;
    logic [1:0]  alu_sel;
    logic        alu_first_val_sel, halted;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] mem_r_addr_sel;
        logic [1:0] mem_w_addr_sel;
        logic       mem_r_prev_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_r0_addr_sel;
        logic       rf_r0_rd;
        logic       rf_r1_rd;
        logic       prev_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_first_val_sel;
        logic       halted;
    } ctl_t;

    localparam logic [1:0] PCS_8_0  = 2'd0;
    localparam logic [1:0] PCS_10_0 = 2'd1;
    localparam logic [1:0] PCS_R1   = 2'd2;
    localparam logic [1:0] MR_PC    = 2'd0;
    localparam logic [1:0] MR_8_0   = 2'd1;
    localparam logic [1:0] MR_R1    = 2'd2;
    localparam logic [1:0] MW_8_0   = 2'd0;
    localparam logic [1:0] MW_R1    = 2'd1;
    localparam logic [1:0] MW_PREV  = 2'd2;
    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MEM   = 2'd1;
    localparam logic [1:0] WD_8_0   = 2'd2;
    localparam logic [1:0] WD_PC    = 2'd3;
    localparam logic       WA_11_9  = 1'b0;
    localparam logic       WA_R7    = 1'b1;
    localparam logic       R0_2_0   = 1'b0;
    localparam logic       R0_11_9  = 1'b1;
    localparam logic [1:0] A_ADD    = 2'd0;
    localparam logic [1:0] A_AND    = 2'd1;
    localparam logic [1:0] A_NOT    = 2'd2;
    localparam logic       FA_R0    = 1'b0;
    localparam logic       FA_IMM   = 1'b1;

`ifdef PUNC_INDIRECT_EN
    localparam bit IND = 1'b1;
`else
    localparam bit IND = 1'b0;
`endif

    int n_chk = 0;
    int n_pass = 0;

    ctl_t  obs;
    ctl_t  exp_q[$];
    string tag_q[$];

    assign obs = {pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd,
                  mem_wr, mem_r_addr_sel, mem_w_addr_sel, mem_r_prev_sel,
                  rf_w_data_sel, rf_w_addr_sel, rf_w_wr, rf_r0_addr_sel,
                  rf_r0_rd, rf_r1_rd, prev_ld, nzp_ld, nzp_clr, alu_sel,
                  alu_first_val_sel, halted};

    punc_controller dut (
        .clk(clk), .rst(rst), .ir(ir), .nzp_true(nzp_true),
        .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
        .ir_ld(ir_ld), .ir_clr(ir_clr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_r_addr_sel(mem_r_addr_sel), .mem_w_addr_sel(mem_w_addr_sel),
        .mem_r_prev_sel(mem_r_prev_sel), .rf_w_data_sel(rf_w_data_sel),
        .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
        .rf_r0_addr_sel(rf_r0_addr_sel), .rf_r0_rd(rf_r0_rd),
        .rf_r1_rd(rf_r1_rd), .prev_ld(prev_ld), .nzp_ld(nzp_ld),
        .nzp_clr(nzp_clr), .alu_sel(alu_sel),
        .alu_first_val_sel(alu_first_val_sel), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [27:0] got,
                         input logic [27:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    function automatic ctl_t v_init();
        ctl_t c = '0;
        c.pc_clr = 1'b1;
        c.ir_clr = 1'b1;
        c.nzp_clr = 1'b1;
        return c;
    endfunction

    function automatic ctl_t v_fetch();
        ctl_t c = '0;
        c.mem_rd = 1'b1;
        c.mem_r_addr_sel = MR_PC;
        c.ir_ld = 1'b1;
        return c;
    endfunction

    function automatic ctl_t v_decode();
        ctl_t c = '0;
        c.pc_inc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t v_halt();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    function automatic ctl_t v_rfw(input ctl_t c, input logic [1:0] src);
        ctl_t r = c;
        r.rf_w_data_sel = src;
        r.rf_w_addr_sel = WA_11_9;
        r.rf_w_wr = 1'b1;
        r.nzp_ld = 1'b1;
        return r;
    endfunction

    task automatic push(input ctl_t c, input string t);
        exp_q.push_back(c);
        tag_q.push_back(t);
    endtask

    // Builds the expected per-cycle outputs for one instruction from FETCH on.
    task automatic plan(input logic [15:0] i, input logic nz, output bit halts);
        logic [3:0] op;
        ctl_t e, e2;
        bit two;
        op = i[15:12];
        e = '0;
        e2 = '0;
        two = 1'b0;
        push(v_fetch(), $sformatf("fetch ir=%h", i));
        push(v_decode(), $sformatf("decode ir=%h", i));
        halts = (op == 4'hF) || (!IND && (op == 4'hA || op == 4'hB));
        if (halts) begin
            for (int k = 0; k < 3; k++)
                push(v_halt(), $sformatf("halt%0d ir=%h", k, i));
            return;
        end
        case (op)
            4'h1, 4'h5: begin
                e.alu_sel = (op == 4'h1) ? A_ADD : A_AND;
                e.rf_r1_rd = 1'b1;
                if (i[5]) e.alu_first_val_sel = FA_IMM;
                else begin
                    e.alu_first_val_sel = FA_R0;
                    e.rf_r0_addr_sel = R0_2_0;
                    e.rf_r0_rd = 1'b1;
                end
                e = v_rfw(e, WD_ALU);
            end
            4'h9: begin
                e.alu_sel = A_NOT;
                e.rf_r1_rd = 1'b1;
                e = v_rfw(e, WD_ALU);
            end
            4'h2: begin
                e.mem_rd = 1'b1;
                e.mem_r_addr_sel = MR_8_0;
                e = v_rfw(e, WD_MEM);
            end
            4'h6: begin
                e.mem_rd = 1'b1;
                e.mem_r_addr_sel = MR_R1;
                e.rf_r1_rd = 1'b1;
                e = v_rfw(e, WD_MEM);
            end
            4'hE: e = v_rfw(e, WD_8_0);
            4'h3, 4'h7: begin
                e.mem_w_addr_sel = (op == 4'h3) ? MW_8_0 : MW_R1;
                e.rf_r1_rd = (op == 4'h7);
                e.rf_r0_addr_sel = R0_11_9;
                e.rf_r0_rd = 1'b1;
                e.mem_wr = 1'b1;
            end
            4'h0: begin
                if (nz && i[11:9] != 3'b000) begin
                    e.pc_ld = 1'b1;
                    e.pc_sel = PCS_8_0;
                end
            end
            4'hC: begin
                e.pc_ld = 1'b1;
                e.pc_sel = PCS_R1;
                e.rf_r1_rd = 1'b1;
            end
            4'h4: begin
                e.rf_w_addr_sel = WA_R7;
                e.rf_w_data_sel = WD_PC;
                e.rf_w_wr = 1'b1;
                e.pc_ld = 1'b1;
                e.pc_sel = i[11] ? PCS_10_0 : PCS_R1;
                e.rf_r1_rd = !i[11];
            end
            4'hA, 4'hB: begin
                two = 1'b1;
                e.mem_rd = 1'b1;
                e.mem_r_addr_sel = MR_8_0;
                e.prev_ld = 1'b1;
                if (op == 4'hA) begin
                    e2.mem_rd = 1'b1;
                    e2.mem_r_prev_sel = 1'b1;
                    e2 = v_rfw(e2, WD_MEM);
                end else begin
                    e2.mem_w_addr_sel = MW_PREV;
                    e2.rf_r0_addr_sel = R0_11_9;
                    e2.rf_r0_rd = 1'b1;
                    e2.mem_wr = 1'b1;
                end
            end
            default: ;
        endcase
        push(e, $sformatf("exec ir=%h nz=%0b", i, nz));
        if (two) push(e2, $sformatf("exec2 ir=%h", i));
    endtask

    task automatic cyc(input string tag, input ctl_t e);
        @(negedge clk);
        check(tag, obs, e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq(input string why);
        rst = 1'b0;
        cyc({why, " rst_low"}, v_init());
        rst = 1'b1;
        cyc({why, " rst_rel"}, v_init());
    endtask

    task automatic run_instr(input logic [15:0] i, input logic nz,
                             input int rst_at);
        bit halts;
        exp_q.delete();
        tag_q.delete();
        plan(i, nz, halts);
        ir = i;
        nzp_true = nz;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == rst_at) begin
                reset_seq($sformatf("mid%0d ir=%h", k, i));
                return;
            end
            // Once halted, input changes must not wake the controller.
            if (halts && k > 2) begin
                ir = 16'($urandom());
                nzp_true = 1'($urandom_range(0, 1));
            end
            cyc(tag_q[k], exp_q[k]);
        end
        if (halts) reset_seq("after_halt");
    endtask

    logic [15:0] d_ir  [12];
    logic        d_nz  [12];
    int          d_rst [12];

    initial begin
        d_ir = '{16'h127F, 16'h0404, 16'h0404, 16'h0004, 16'h4810,
                 16'h41C0, 16'hB401, 16'hA401, 16'hF025, 16'h8000,
                 16'hD123, 16'h1042};
        d_nz = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b1, 1'b1, 1'b0};
        d_rst = '{-1, -1, -1, -1, -1, -1, -1, 3, -1, -1, -1, 2};

        rst = 1'b0;
        ir = 16'h0000;
        nzp_true = 1'b0;
        #1;
        check("rst_pre_edge", obs, v_init());
        @(posedge clk);
        #1;
        cyc("rst_low0", v_init());
        cyc("rst_low1", v_init());
        rst = 1'b1;
        cyc("init_after_rst", v_init());

        for (int n = 0; n < 12; n++)
            run_instr(d_ir[n], d_nz[n], d_rst[n]);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] r;
            logic [15:0] i;
            int ra;
            r = $urandom();
            i = r[15:0];
            ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(i, 1'($urandom_range(0, 1)), ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/punc_controller.md
PUNC_CONTROLLER -- requirements
Module: punc_controller

Interface
REQ-001 Parameters: none; every select encoding SHALL use the Defines.v macros.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 ir  in  16  current instruction from datapath.
REQ-005 nzp_true  in  1  branch condition (ir[11:9] AND latched nzp).
REQ-006 pc_ld, pc_clr, pc_inc  out  1 each  PC load, clear, increment.
REQ-007 pc_sel  out  2  PC source.
REQ-008 ir_ld, ir_clr  out  1 each  IR load, clear.
REQ-009 mem_rd, mem_wr  out  1 each  memory read, write.
REQ-010 mem_r_addr_sel, mem_w_addr_sel  out  2 each  memory address selects.
REQ-011 mem_r_prev_sel  out  1  read address override with prev; datapath adds the matching mux input.
REQ-012 rf_w_data_sel  out  2  RF write-data select.
REQ-013 rf_w_addr_sel, rf_w_wr  out  1 each  RF write address select, write enable.
REQ-014 rf_r0_addr_sel, rf_r0_rd, rf_r1_rd  out  1 each  RF read controls.
REQ-015 prev_ld, nzp_ld, nzp_clr  out  1 each  prev load; NZP load, clear.
REQ-016 alu_sel  out  2  ALU operation.
REQ-017 alu_first_val_sel  out  1  ALU operand A select.
REQ-018 halted  out  1  high in HALT state.

Function
REQ-019 States SHALL be INIT, FETCH, DECODE, EXEC, EXEC2, HALT; all outputs are combinational from state, ir and nzp_true; any output not named for a state is 0.
REQ-020 INIT: pc_clr=ir_clr=nzp_clr=1; next FETCH.
REQ-021 FETCH: mem_rd=1, mem_r_addr_sel=PC, ir_ld=1; next DECODE.
REQ-022 DECODE: pc_inc=1; next HALT if ir[15:12]=1111, else EXEC.
REQ-023 ADD(0001)/AND(0101): ALU ADD/AND; ir[5]=1 -> alu_first_val_sel=4_0, else R0_Data with rf_r0_addr_sel=2_0; rf_w_data_sel=ALU, rf_w_addr_sel=11_9, rf_w_wr=1, nzp_ld=1.
REQ-024 NOT(1001): alu_sel=NOT_B; RF write to ir[11:9] and nzp_ld as in REQ-023.
REQ-025 LD(0010)/LDR(0110): mem_r_addr_sel=PC_8_0 or RF_R1_5_0; rf_w_data_sel=Mem_R, write ir[11:9], nzp_ld=1.
REQ-026 LEA(1110): rf_w_data_sel=PC_8_0, write ir[11:9], nzp_ld=1.
REQ-027 ST(0011)/STR(0111): mem_w_addr_sel=PC_8_0 or RF_R1_5_0, rf_r0_addr_sel=11_9, mem_wr=1.
REQ-028 BR(0000): pc_ld=1 with pc_sel=PC_8_0 only when nzp_true=1; ir[11:9]=000 never branches.
REQ-029 JMP(1100): pc_sel=RF_R1_Data, pc_ld=1.
REQ-030 JSR(0100): rf_w_addr_sel=R7, rf_w_data_sel=PC, rf_w_wr=1, pc_ld=1 in same cycle; ir[11]=1 -> pc_sel=PC_10_0, else RF_R1_Data (old R7 used when BaseR=R7).
REQ-031 Single-EXEC instructions SHALL return to FETCH after EXEC: 3 cycles per instruction.
REQ-032 HALT: halted=1, all strobes 0; remains until reset.
REQ-033 Opcodes 1000 and 1101 SHALL execute as NOP (EXEC with no strobes) unless REQ-037 applies.

Reset
REQ-034 rst sampled low at posedge SHALL force state to INIT, from any state including EXEC2 mid-instruction.
REQ-035 While rst is low, outputs SHALL equal INIT outputs (clears=1, all other strobes 0, halted=0); first FETCH occurs on the second cycle after rst rises.

Configuration
REQ-036 Macro PUNC_INDIRECT_EN defined: LDI(1010): EXEC mem_r_addr_sel=PC_8_0, prev_ld=1; EXEC2 mem_r_prev_sel=1, write Mem_R to ir[11:9], nzp_ld=1. STI(1011): EXEC prev_ld as LDI; EXEC2 mem_w_addr_sel=prev_Data, rf_r0_addr_sel=11_9, mem_wr=1. Both take 4 cycles.
REQ-037 Macro undefined: EXEC2 unreachable, mem_r_prev_sel tied 0, and 1010/1011 SHALL enter HALT from DECODE, as illegal opcodes.

Verification
REQ-038 rst low 2 cycles then high -> INIT clears asserted; FETCH with pc_ld=0 at PC=0x0000.
REQ-039 ADD R1,R1,#-1 (0x127F) with R1=0 -> R1=0xFFFF, n=1, PC +1 after 3 cycles.
REQ-040 BRz +4 (0x0404) with z=1 -> PC=0x0005 from 0x0000; with p=1 only -> PC=0x0001.
REQ-041 JSR +16 (0x4810) at 0x0003 -> R7=0x0004, PC=0x0014 in the same edge.
REQ-042 STI R2 (0xB401) with mem[PC+1+1]=0x0030, R2=0xBEEF, PUNC_INDIRECT_EN -> mem[0x0030]=0xBEEF after 4 cycles; undefined -> halted=1.
REQ-043 rst low during EXEC2 of LDI -> no rf_w_wr, state INIT; 0xF025 -> halted=1, PC frozen.
